mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one mux8 between 8 byte-wide requesters and sequences transfers through it. It selects one requester and drives the mux sel. It registers the mux output into a valid/ready output stage and returns per-beat acknowledges. Sits between the 8 source ports (register/IO sources) and the single 8-bit consumer bus.

---
 rtl/mux8_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that time-shares one mux8 between 8 byte-wide requesters and registers the result into a valid/ready stage.
// Optional build macro MUX8_ARB_PRIO0_EN makes requester 0 a fixed high-priority port.
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int DW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    req,
   input  logic [7:0]    last,
   input  logic [DW-1:0] mux_out,
   output logic [2:0]    sel,
   output logic [7:0]    gnt,
   output logic [7:0]    ack,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam logic [3:0] HOLD = 4'(MAX_HOLD);

   state_t        state_q, state_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    sel_q, sel_d;
   logic [7:0]    gnt_q, gnt_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;

   logic [2:0]    win;
   logic [2:0]    next_ptr;
   logic          owner_req;
   logic          owner_last;
   logic          beat;
   logic          hold_hit;
   logic          leave;

   // Rotate the request vector so ptr sits at bit 0, then take the lowest set bit.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [15:0] dbl;
      logic [7:0]  rot;
      logic [2:0]  off;
      dbl = {r, r} >> p;
      rot = dbl[7:0];
      off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rot[i]) off = 3'(i);
      end
      return p + off;
   endfunction

`ifdef MUX8_ARB_PRIO0_EN
   assign win      = req[0] ? 3'd0 : rr_pick(req, ptr_q);
   assign next_ptr = (sel_q == 3'd0) ? ptr_q : sel_q + 3'd1;
`else
   assign win      = rr_pick(req, ptr_q);
   assign next_ptr = sel_q + 3'd1;
`endif

   assign owner_req  = req[sel_q];
   assign owner_last = last[sel_q];

   // A beat is suppressed while rst is high so a reset mid-burst never acknowledges.
   assign beat     = (state_q == OWN) & owner_req & (~valid_q | out_ready) & ~rst;
   assign hold_hit = (cnt_q + 4'd1) == HOLD;
   assign leave    = (state_q == OWN) & (~owner_req | (beat & (owner_last | hold_hit)));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req) state_d = OWN;
         OWN:     if (leave) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack  = beat ? gnt_q : 8'd0;
      busy = (state_q == OWN);
   end

   always_comb begin
      sel_d = sel_q;
      gnt_d = gnt_q;
      cnt_d = cnt_q;
      ptr_d = ptr_q;
      if ((state_q == IDLE) && (|req)) begin
         sel_d = win;
         gnt_d = 8'd1 << win;
         cnt_d = 4'd0;
      end
      if (beat) cnt_d = cnt_q + 4'd1;
      // sel deliberately keeps the last owner after release.
      if (leave) begin
         gnt_d = 8'd0;
         ptr_d = next_ptr;
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (beat) begin
         data_d  = mux_out;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= 3'd0;
         sel_q   <= 3'd0;
         gnt_q   <= 8'd0;
         cnt_q   <= 4'd0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign sel       = sel_q;
   assign gnt       = gnt_q;
   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: per-port data queues feed a modelled mux8; a transaction-level model predicts every output each cycle.
module tb_mux8_rr_arbiter;
   localparam int MAX_HOLD = 4;
   localparam int DW       = 8;

   logic          clk, rst;
   logic [7:0]    req, last;
   logic [DW-1:0] mux_out;
   logic [2:0]    sel;
   logic [7:0]    gnt, ack;
   logic [DW-1:0] out_data;
   logic          out_valid, out_ready, busy;

   logic [7:0]    src [8];
   logic [7:0]    pq [8][$];
   bit            lm [8];

   int            m_own, m_ptr, m_cnt, m_sel;
   logic [7:0]    m_od;
   bit            m_ov;
   int            pend_pop;
   int            total, bad;

   mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last), .mux_out(mux_out),
      .sel(sel), .gnt(gnt), .ack(ack), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   assign mux_out = src[sel];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [7:0] r, input int p);
`ifdef MUX8_ARB_PRIO0_EN
      if (r[0]) return 0;
`endif
      for (int i = 0; i < 8; i++) if (r[(p + i) % 8]) return (p + i) % 8;
      return -1;
   endfunction

   function automatic bit all_empty();
      for (int p = 0; p < 8; p++) if (pq[p].size() != 0) return 0;
      return 1;
   endfunction

   task automatic model_reset();
      m_own = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_od = 8'h00; m_ov = 0;
   endtask

   // Compare DUT against the model for this cycle, then advance the model across the coming edge.
   task automatic model_cycle();
      logic [7:0] e_gnt, e_ack;
      bit beat, done;
      beat  = (m_own >= 0) && req[m_own] && (!m_ov || out_ready) && !rst;
      e_gnt = (m_own >= 0) ? 8'(1 << m_own) : 8'h00;
      e_ack = beat ? e_gnt : 8'h00;
      chk("gnt", gnt, e_gnt);
      chk("ack", ack, e_ack);
      chk("sel", sel, m_sel);
      chk("busy", busy, m_own >= 0);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      pend_pop = beat ? m_own : -1;
      if (rst) begin
         model_reset();
      end else if (m_own < 0) begin
         if (m_ov && out_ready) m_ov = 0;
         if (req != 8'h00) begin
            m_own = pick(req, m_ptr);
            m_sel = m_own;
            m_cnt = 0;
         end
      end else begin
         if (beat) begin
            m_od = src[m_own];
            m_ov = 1;
            m_cnt++;
            done = last[m_own] || (m_cnt == MAX_HOLD);
         end else begin
            if (m_ov && out_ready) m_ov = 0;
            done = !req[m_own];
         end
         if (done) begin
`ifdef MUX8_ARB_PRIO0_EN
            if (m_own != 0) m_ptr = (m_own + 1) % 8;
`else
            m_ptr = (m_own + 1) % 8;
`endif
            m_own = -1;
         end
      end
   endtask

   task automatic drive();
      for (int p = 0; p < 8; p++) begin
         req[p]  = pq[p].size() != 0;
         last[p] = lm[p] && (pq[p].size() == 1);
         src[p]  = (pq[p].size() != 0) ? pq[p][0] : 8'h00;
      end
   endtask

   task automatic step();
      drive();
      @(negedge clk);
      model_cycle();
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
      if (pend_pop >= 0 && pq[pend_pop].size() != 0) void'(pq[pend_pop].pop_front());
      pend_pop = -1;
   endtask

   task automatic run_idle(input int maxc);
      int n;
      n = 0;
      while (!(all_empty() && m_own < 0 && !m_ov) && n < maxc) begin
         step(); edge_(); n++;
      end
      total++;
      if (n >= maxc) begin
         bad++;
         $display("FAIL drain: still active after %0d cycles, want idle", n);
      end
      repeat (2) begin step(); edge_(); end
   endtask

   task automatic wait_gnt(input string nm, input logic [7:0] g);
      int w;
      w = 0;
      step();
      while (gnt !== g && w < 10) begin
         edge_(); step(); w++;
      end
      chk(nm, gnt, g);
   endtask

   initial begin
      int         gseq[$];
      int         acnt[$];
      logic [7:0] acc[$];
      logic [7:0] prevg;
      bit         nogap;
      int         exp_seq[4];

      total = 0; bad = 0; pend_pop = -1;
      rst = 1'b1; out_ready = 1'b1;
      for (int p = 0; p < 8; p++) begin
         pq[p].delete();
         lm[p] = 1;
         pq[p].push_back(8'(8'h10 + p));
      end
      drive();
      @(posedge clk); #1;
      model_reset();

      // Reset held for two cycles with every port requesting.
      step();
      chk("rst_gnt", gnt, 8'h00); chk("rst_ack", ack, 8'h00); chk("rst_valid", out_valid, 0);
      chk("rst_sel", sel, 0); chk("rst_busy", busy, 0);
      edge_();
      step(); chk("rst_gnt2", gnt, 8'h00);
      edge_();
      rst = 1'b0;
      step(); chk("rel_idle", gnt, 8'h00);
      edge_();
      step(); chk("first_gnt", gnt, 8'h01); chk("first_ack", ack, 8'h01);
      edge_();
      run_idle(100);

      // Single 3-beat burst on port 2.
      pq[2] = '{8'hA1, 8'hA2, 8'hA3}; lm[2] = 1;
      step(); chk("b_idle", gnt, 8'h00); edge_();
      step(); chk("b_gnt", gnt, 8'h04); chk("b_sel", sel, 2); chk("b_ack0", ack, 8'h04); edge_();
      step(); chk("b_ack1", ack, 8'h04); chk("b_d1", out_data, 8'hA1); edge_();
      step(); chk("b_ack2", ack, 8'h04); chk("b_d2", out_data, 8'hA2); edge_();
      step(); chk("b_end_gnt", gnt, 8'h00); chk("b_end_ack", ack, 8'h00);
      chk("b_d3", out_data, 8'hA3); chk("b_d3v", out_valid, 1); chk("b_busy", busy, 0);
      edge_();
      pq[0] = '{8'h55}; pq[3] = '{8'h66}; lm[0] = 1; lm[3] = 1;
      step(); edge_();
      step(); chk("ptr3", gnt, 8'h08); edge_();
      run_idle(40);
      pq[6] = '{8'h77}; lm[6] = 1;
      run_idle(40);

      // Ports 7 and 0 both streaming without last, pointer at 7.
      for (int i = 0; i < 8; i++) begin
         pq[7].push_back(8'(8'h70 + i));
         pq[0].push_back(8'(8'h00 + i));
      end
      lm[7] = 0; lm[0] = 0;
      prevg = 8'h00; nogap = 1;
      for (int c = 0; c < 60 && !(all_empty() && m_own < 0); c++) begin
         step();
         if (gnt != 8'h00 && gnt != prevg) begin
            int ix;
            ix = -1;
            if (prevg != 8'h00) nogap = 0;
            for (int b = 0; b < 8; b++) if (gnt[b]) ix = b;
            gseq.push_back(ix);
            acnt.push_back(0);
         end
         if (ack != 8'h00 && acnt.size() > 0) acnt[acnt.size() - 1] += 1;
         prevg = gnt;
         edge_();
      end
      exp_seq = '{7, 0, 7, 0};
      chk("rr_ngrants", gseq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("rr_order", (i < gseq.size()) ? gseq[i] : -1, exp_seq[i]);
         chk("rr_acks", (i < acnt.size()) ? acnt[i] : -1, 4);
      end
      chk("rr_gap", nogap, 1);
      run_idle(40);

      // Backpressure on owner 5.
      pq[5] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4}; lm[5] = 1;
      wait_gnt("bp_gnt", 8'h20);
      chk("bp_ack0", ack, 8'h20);
      edge_();
      out_ready = 1'b0;
      repeat (3) begin
         step();
         chk("bp_stall_ack", ack, 8'h00); chk("bp_hold", gnt, 8'h20); chk("bp_frozen", out_data, 8'hC1);
         edge_();
      end
      out_ready = 1'b1;
      repeat (8) begin
         step();
         if (out_valid && out_ready) acc.push_back(out_data);
         edge_();
      end
      chk("bp_count", acc.size(), 4);
      for (int i = 0; i < 4; i++) chk("bp_data", (i < acc.size()) ? acc[i] : 8'hxx, 8'(8'hC1 + i));
      run_idle(40);

      // Owner 3 withdraws after one beat; pointer must land on 4.
      pq[3] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35}; lm[3] = 0;
      wait_gnt("wd_gnt", 8'h08);
      chk("wd_ack0", ack, 8'h08);
      edge_();
      pq[3].delete();
      step(); chk("wd_noack", ack, 8'h00); chk("wd_gnt_hold", gnt, 8'h08); edge_();
      step(); chk("wd_idle", gnt, 8'h00); chk("wd_busy", busy, 0); edge_();
      pq[0] = '{8'h01}; pq[4] = '{8'h02}; lm[0] = 1; lm[4] = 1;
      step(); edge_();
`ifdef MUX8_ARB_PRIO0_EN
      step(); chk("prio_order", gnt, 8'h01); edge_();
`else
      step(); chk("prio_order", gnt, 8'h10); edge_();
`endif
      run_idle(40);

      // Reset pulsed in the middle of a burst.
      pq[6] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66}; lm[6] = 0;
      wait_gnt("mr_gnt", 8'h40);
      edge_();
      step(); edge_();
      rst = 1'b1;
      step(); chk("mr_noack", ack, 8'h00); edge_();
      rst = 1'b0;
      pq[6].delete();
      step();
      chk("mr_gnt0", gnt, 8'h00); chk("mr_ack0", ack, 8'h00); chk("mr_valid0", out_valid, 0);
      chk("mr_data0", out_data, 8'h00); chk("mr_sel0", sel, 0); chk("mr_busy0", busy, 0);
      edge_();

      // Randomized traffic with backpressure, withdrawals and occasional resets.
      for (int c = 0; c < 2000; c++) begin
         for (int p = 0; p < 8; p++) begin
            if (pq[p].size() == 0 && $urandom % 8 == 0) begin
               int n;
               n = $urandom_range(1, 6);
               for (int k = 0; k < n; k++) pq[p].push_back(8'($urandom));
               lm[p] = ($urandom % 3) != 0;
            end
         end
         if ($urandom % 60 == 0) pq[$urandom % 8].delete();
         out_ready = ($urandom % 4) != 0;
         rst = ($urandom % 500) == 0;
         step(); edge_();
      end
      rst = 1'b0; out_ready = 1'b1;
      for (int p = 0; p < 8; p++) pq[p].delete();
      run_idle(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
